// File: rtl/sig_noise_gen.sv
// sig_noise_gen: sine/square/triangle sample source with optional LFSR noise.
// Define SIG_NOISE_GEN_NOISE_EN to build the LFSR and saturating noise adder.
module sig_noise_gen #(
   parameter logic [15:0] AMP  = 16'h3FFF,
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               enable,
   input  logic [1:0]         sel,
   input  logic [15:0]        phase_inc,
   input  logic [7:0]         sample_div,
   input  logic [3:0]         noise_shift,
   input  logic               overrun_clr,
   input  logic               out_ready,
   output logic               out_valid,
   output logic signed [15:0] noisy_signal,
   output logic               overrun
);

   // Quarter-wave table, entry k = round(AMP*sin(pi/2*k/64)), 16 bits each.
   function automatic logic [1023:0] build_rom();
      logic [1023:0] t;
      real           r;
      t = '0;
      for (int k = 0; k < 64; k++) begin
         r = real'(AMP) * $sin(3.14159265358979323846 / 2.0 * real'(k) / 64.0);
         t[k*16 +: 16] = 16'($rtoi(r + 0.5));
      end
      return t;
   endfunction

   localparam logic [1023:0] ROM = build_rom();

   logic [7:0]  cnt;
   logic [7:0]  div_q;
   logic [7:0]  div_eff;
   logic        strobe;
   logic [15:0] phase;
   logic [5:0]  idx;
   logic [15:0] mag;
   logic [15:0] tri_val;
   logic [15:0] wave;
   logic [15:0] sample;

   // The divisor is captured at the start of each period so a new
   // sample_div only matters once the current period wraps.
   always_comb begin
      div_eff = (cnt == 8'd0) ? sample_div : div_q;
      strobe  = enable && (cnt == div_eff);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt   <= '0;
         div_q <= '0;
      end else begin
         if (cnt == 8'd0)
            div_q <= sample_div;
         if (!enable || strobe)
            cnt <= '0;
         else
            cnt <= cnt + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         phase <= '0;
      else if (strobe)
         phase <= phase + phase_inc;
   end

   always_comb begin
      idx     = phase[14] ? ~phase[13:8] : phase[13:8];
      mag     = ROM[{idx, 4'b0000} +: 16];
      tri_val = {1'b0, phase[15] ? ~phase[14:0] : phase[14:0]};
      wave    = '0;
      unique case (1'b1)
         sel == 2'd0: wave = phase[15] ? -mag : mag;
         sel == 2'd1: wave = phase[15] ? -AMP : AMP;
         sel == 2'd2: wave = tri_val - 16'h4000;
         default:     wave = '0;
      endcase
   end

`ifdef SIG_NOISE_GEN_NOISE_EN
   logic [15:0]        lfsr;
   logic signed [15:0] noise;
   logic signed [16:0] sum;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         lfsr <= SEED;
      else if (strobe)
         lfsr <= (lfsr >> 1) ^ (lfsr[0] ? 16'hB400 : 16'h0000);
   end

   // One guard bit lets the sum be clamped instead of wrapping.
   always_comb begin
      noise = '0;
      if (noise_shift != 4'hF)
         noise = $signed(lfsr) >>> noise_shift;
      sum    = {wave[15], wave} + {noise[15], noise};
      sample = sum[15:0];
      if (sum[16] != sum[15])
         sample = sum[16] ? 16'h8000 : 16'h7FFF;
   end
`else
   logic unused_noise;
   assign unused_noise = ^noise_shift;
   assign sample       = wave;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid    <= 1'b0;
         noisy_signal <= '0;
      end else if (strobe && (!out_valid || out_ready)) begin
         out_valid    <= 1'b1;
         noisy_signal <= sample;
      end else if (!strobe && out_valid && out_ready) begin
         out_valid    <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         overrun <= 1'b0;
      else if (strobe && out_valid && !out_ready)
         overrun <= 1'b1;
      else if (overrun_clr)
         overrun <= 1'b0;
   end

endmodule

// File: tb/tb_sig_noise_gen.sv
// tb_sig_noise_gen: random and directed checks against a sample-level model.
// Honours SIG_NOISE_GEN_NOISE_EN the same way as the design.
module tb_sig_noise_gen;

   localparam int AMP_I = 16383;
   localparam logic [15:0] SEED_V = 16'hACE1;
`ifdef SIG_NOISE_GEN_NOISE_EN
   localparam bit NOISE_ON = 1'b1;
`else
   localparam bit NOISE_ON = 1'b0;
`endif

   logic               clk = 1'b0;
   logic               rst_n;
   logic               enable;
   logic [1:0]         sel;
   logic [15:0]        phase_inc;
   logic [7:0]         sample_div;
   logic [3:0]         noise_shift;
   logic               overrun_clr;
   logic               out_ready;
   logic               out_valid;
   logic signed [15:0] noisy_signal;
   logic               overrun;

   int n_checks = 0;
   int n_err    = 0;

   int          m_p;
   logic [15:0] m_lfsr;
   bit          m_valid;
   bit          m_ovr;
   logic [15:0] m_data;
   int          m_cnt;
   int          m_div;

   sig_noise_gen dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .enable       (enable),
      .sel          (sel),
      .phase_inc    (phase_inc),
      .sample_div   (sample_div),
      .noise_shift  (noise_shift),
      .overrun_clr  (overrun_clr),
      .out_ready    (out_ready),
      .out_valid    (out_valid),
      .noisy_signal (noisy_signal),
      .overrun      (overrun)
   );

   always #5 clk = ~clk;

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic int rom_ref(int k);
      real r;
      r = real'(AMP_I) * $sin(3.14159265358979323846 / 2.0 * real'(k) / 64.0);
      return $rtoi(r + 0.5);
   endfunction

   function automatic logic [15:0] ref_sample(int p, logic [15:0] l, int s, int ns);
      int w, n, t, k, sl, sum;
      w = 0;
      n = 0;
      case (s)
         0: begin
            k = (p / 256) % 64;
            if ((p / 16384) % 2 == 1) k = 63 - k;
            t = rom_ref(k);
            w = (p >= 32768) ? -t : t;
         end
         1: w = (p < 32768) ? AMP_I : -AMP_I;
         2: begin
            t = p % 32768;
            if (p >= 32768) t = 32767 - t;
            w = t - 16384;
         end
         default: w = 0;
      endcase
      sl = int'(l);
      if (sl >= 32768) sl = sl - 65536;
      if (NOISE_ON && ns != 15) n = sl >>> ns;
      sum = w + n;
      if (sum > 32767) sum = 32767;
      if (sum < -32768) sum = -32768;
      return 16'(sum);
   endfunction

   task automatic model_reset();
      m_p     = 0;
      m_lfsr  = SEED_V;
      m_valid = 0;
      m_ovr   = 0;
      m_data  = '0;
      m_cnt   = 0;
      m_div   = 0;
   endtask

   task automatic model_tick();
      bit          stb, v0, set;
      logic [15:0] s;
      stb = 0;
      set = 0;
      v0  = m_valid;
      if (enable) begin
         if (m_cnt == 0) m_div = int'(sample_div);
         stb   = (m_cnt == m_div);
         m_cnt = stb ? 0 : m_cnt + 1;
      end else begin
         m_cnt = 0;
      end
      if (stb) begin
         s = ref_sample(m_p, m_lfsr, int'(sel), int'(noise_shift));
         if (!v0 || out_ready) begin
            m_valid = 1;
            m_data  = s;
         end else begin
            set = 1;
         end
         m_p    = (m_p + int'(phase_inc)) % 65536;
         m_lfsr = {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
      end else if (v0 && out_ready) begin
         m_valid = 0;
      end
      if (set) m_ovr = 1;
      else if (overrun_clr) m_ovr = 0;
   endtask

   task automatic step();
      @(posedge clk);
      model_tick();
      #1;
      chk("valid", 32'(out_valid), 32'(m_valid));
      chk("overrun", 32'(overrun), 32'(m_ovr));
      if (m_valid)
         chk("data", 32'($unsigned(noisy_signal)), 32'(m_data));
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_data", 32'($unsigned(noisy_signal)), 32'd0);
      chk("rst_ovr", 32'(overrun), 32'd0);
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic cfg(logic [1:0] s, logic [15:0] inc, logic [7:0] dv,
                      logic [3:0] ns, logic rdy);
      enable      = 1'b1;
      sel         = s;
      phase_inc   = inc;
      sample_div  = dv;
      noise_shift = ns;
      out_ready   = rdy;
      overrun_clr = 1'b0;
   endtask

   logic [15:0] sq_exp [4];
   logic [15:0] tr_exp [4];

   initial begin
      sq_exp = '{16'h3FFF, 16'h3FFF, 16'hC001, 16'hC001};
      tr_exp = '{16'hC000, 16'h0000, 16'h3FFF, 16'hFFFF};
      rst_n = 1'b0;
      cfg(2'd1, 16'h4000, 8'd0, 4'hF, 1'b1);
      enable = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("init_valid", 32'(out_valid), 32'd0);
      chk("init_data", 32'($unsigned(noisy_signal)), 32'd0);
      chk("init_ovr", 32'(overrun), 32'd0);
      model_reset();
      rst_n = 1'b1;

      cfg(2'd1, 16'h4000, 8'd0, 4'hF, 1'b1);
      for (int i = 0; i < 8; i++) begin
         step();
         chk("square", 32'($unsigned(noisy_signal)), 32'(sq_exp[i % 4]));
      end

      do_reset();
      cfg(2'd2, 16'h4000, 8'd0, 4'hF, 1'b1);
      for (int i = 0; i < 8; i++) begin
         step();
         chk("triangle", 32'($unsigned(noisy_signal)), 32'(tr_exp[i % 4]));
      end

      do_reset();
      cfg(2'd1, 16'h4000, 8'd0, 4'h0, 1'b1);
      step();
      chk("noise_first", 32'($unsigned(noisy_signal)),
          NOISE_ON ? 32'h0000ECE0 : 32'h00003FFF);
      for (int i = 1; i < 4; i++) begin
         step();
         if (!NOISE_ON)
            chk("clean_sq", 32'($unsigned(noisy_signal)), 32'(sq_exp[i]));
      end
      for (int i = 4; i < 4096; i++) step();

      do_reset();
      cfg(2'd1, 16'h4000, 8'd3, 4'hF, 1'b0);
      for (int i = 0; i < 4; i++) step();
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_first", 32'($unsigned(noisy_signal)), 32'h3FFF);
      for (int i = 0; i < 4; i++) step();
      chk("bp_ovr", 32'(overrun), 32'd1);
      chk("bp_hold", 32'($unsigned(noisy_signal)), 32'h3FFF);
      out_ready = 1'b1;
      step();
      chk("bp_accept", 32'(out_valid), 32'd0);
      out_ready   = 1'b0;
      overrun_clr = 1'b1;
      step();
      chk("bp_clr", 32'(overrun), 32'd0);
      overrun_clr = 1'b0;
      for (int i = 0; i < 6; i++) step();

      do_reset();
      cfg(2'd0, 16'h0100, 8'd0, 4'h3, 1'b1);
      for (int i = 0; i < 260; i++) step();

      for (int i = 0; i < 3000; i++) begin
         enable      = ($urandom_range(9, 0) != 0);
         out_ready   = ($urandom_range(9, 0) < 6);
         overrun_clr = ($urandom_range(9, 0) == 0);
         sel         = 2'($urandom_range(3, 0));
         phase_inc   = 16'($urandom);
         noise_shift = 4'($urandom_range(15, 0));
         if ($urandom_range(19, 0) == 0)
            sample_div = 8'($urandom_range(4, 0));
         if ($urandom_range(299, 0) == 0)
            do_reset();
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
